// File: rtl/tcdm_stream_pkg.sv
// Shared types for the TCDM stream master: FSM states, transfer descriptor,
// TCDM request slot layout and the wen encodings.
package tcdm_stream_pkg;

    localparam logic TCDM_RD = 1'b1;
    localparam logic TCDM_WR = 1'b0;

    // Descriptor length is stored at full width; the top zero-extends cfg_len_i.
    localparam int unsigned DESC_LEN_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0]           base;
        logic [31:0]           stride;
        logic [DESC_LEN_W-1:0] len;
        logic                  write;
    } desc_t;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

endpackage

// File: rtl/tcdm_stream_fifo.sv
// Read-return FIFO: synchronous, power-of-two depth, occupancy count output
// and a flush that empties it in one cycle. Push and pop may coincide at any
// fill level, including full; there is no empty bypass.
module tcdm_stream_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;
    logic              full, do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign count_o = cnt_q;
    // Head word is forced to zero while empty so the stream data output is clean.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array, written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_stream_master.sv
// TCDM stream master: walks a strided descriptor and issues one TCDM request
// per word. Reads land in a credit-limited return FIFO feeding the output
// stream; writes pull words from the input stream.
// Optional macro TCDM_STREAM_MASTER_PERF_EN adds perf_stall_o (req & ~gnt cycles).
module tcdm_stream_master
    import tcdm_stream_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [31:0]      cfg_base_addr_i,
    input  logic [31:0]      cfg_stride_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_write_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [31:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             tcdm_req_o,
    input  logic             tcdm_gnt_i,
    output logic [31:0]      tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [3:0]       tcdm_be_o,
    output logic [31:0]      tcdm_data_o,
    input  logic [31:0]      tcdm_r_data_i,
    input  logic             tcdm_r_valid_i
`ifdef TCDM_STREAM_MASTER_PERF_EN
    ,
    output logic [31:0]      perf_stall_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e           state_q, state_d;
    desc_t            desc_q, desc_d;
    logic [LEN_W-1:0] issued_q, issued_d, loaded_q, loaded_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [31:0]      off_q, off_d;
    logic             slot_vld_q, slot_vld_d;
    tcdm_req_t        slot_q, slot_d;

    logic [CW-1:0]    fifo_cnt;
    logic             fifo_empty;
    logic             gnt_fire, rvalid_acc, start_acc, start_load;
    logic             words_left, slot_free, credit_ok, rd_load, wr_load, drain_ok;

    assign gnt_fire   = slot_vld_q & tcdm_gnt_i;
    // Responses are only meaningful while a transfer owns outstanding requests.
    assign rvalid_acc = tcdm_r_valid_i & (state_q != IDLE) & (outst_q != '0);
    assign start_acc  = (state_q == IDLE) & start_i & ~clear_i;
    // A read transfer preloads its first request at start so it is on the bus next cycle.
    assign start_load = start_acc & ~cfg_write_i & (cfg_len_i != '0);
    assign words_left = (32'(loaded_q) != desc_q.len);
    assign slot_free  = ~slot_vld_q | gnt_fire;
    // Every word in the FIFO, in flight, or waiting in the slot holds a FIFO credit.
    assign credit_ok  = (32'(fifo_cnt) + 32'(outst_q) + 32'(slot_vld_q)) < FIFO_DEPTH;
    assign rd_load    = (state_q == RUN) & ~desc_q.write & words_left & slot_free
                      & credit_ok & ~clear_i;
    assign in_ready_o = (state_q == RUN) & desc_q.write & words_left & slot_free & ~clear_i;
    assign wr_load    = in_ready_o & in_valid_i;
    assign drain_ok   = (outst_q == '0) & (desc_q.write | fifo_empty);

    assign tcdm_req_o  = slot_vld_q;
    assign tcdm_add_o  = slot_q.add;
    assign tcdm_wen_o  = slot_q.wen;
    assign tcdm_be_o   = slot_q.be;
    assign tcdm_data_o = slot_q.data;
    assign out_valid_o = ~fifo_empty;

    tcdm_stream_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (rvalid_acc & ~desc_q.write & ~clear_i),
        .data_i  (tcdm_r_data_i),
        .pop_i   (out_ready_i & ~fifo_empty),
        .data_o  (out_data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; clear returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (32'(issued_q) == desc_q.len) state_d = DRAIN;
            DRAIN:   if (drain_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // FSM outputs: busy level and the completion pulse on DRAIN -> IDLE.
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DRAIN) & drain_ok & ~clear_i;
    end

    // Descriptor, counters and request slot next state.
    always_comb begin
        desc_d     = desc_q;
        issued_d   = issued_q;
        loaded_d   = loaded_q;
        outst_d    = outst_q;
        off_d      = off_q;
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        if (clear_i) begin
            issued_d   = '0;
            loaded_d   = '0;
            outst_d    = '0;
            off_d      = '0;
            slot_vld_d = 1'b0;
        end else if (start_acc) begin
            desc_d   = '{base: cfg_base_addr_i, stride: cfg_stride_i,
                         len: DESC_LEN_W'(cfg_len_i), write: cfg_write_i};
            issued_d = '0;
            loaded_d = '0;
            outst_d  = '0;
            off_d    = '0;
            if (start_load) begin
                slot_vld_d = 1'b1;
                slot_d     = '{add: cfg_base_addr_i, wen: TCDM_RD, be: 4'hF, data: '0};
                off_d      = cfg_stride_i;
                loaded_d   = LEN_W'(1);
            end
        end else begin
            outst_d = outst_q + CW'(gnt_fire) - CW'(rvalid_acc);
            if (gnt_fire) begin
                issued_d   = issued_q + LEN_W'(1);
                slot_vld_d = 1'b0;
            end
            if (rd_load || wr_load) begin
                slot_vld_d = 1'b1;
                slot_d     = '{add:  desc_q.base + off_q,
                               wen:  desc_q.write ? TCDM_WR : TCDM_RD,
                               be:   4'hF,
                               data: desc_q.write ? in_data_i : 32'h0};
                off_d      = off_q + desc_q.stride;
                loaded_d   = loaded_q + LEN_W'(1);
            end
        end
    end

    // Descriptor, counters and request slot registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            desc_q     <= '0;
            issued_q   <= '0;
            loaded_q   <= '0;
            outst_q    <= '0;
            off_q      <= '0;
            slot_vld_q <= 1'b0;
            slot_q     <= '0;
        end else begin
            desc_q     <= desc_d;
            issued_q   <= issued_d;
            loaded_q   <= loaded_d;
            outst_q    <= outst_d;
            off_q      <= off_d;
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
        end
    end

`ifdef TCDM_STREAM_MASTER_PERF_EN
    logic [31:0] perf_q;
    assign perf_stall_o = perf_q;

    // Stall cycle counter for the current transfer, saturating, held after done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     perf_q <= '0;
        else if (clear_i || start_acc)   perf_q <= '0;
        else if ((state_q != IDLE) && slot_vld_q && !tcdm_gnt_i && (perf_q != '1))
            perf_q <= perf_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_tcdm_stream_master.sv
// Directed bench for tcdm_stream_master with a small TCDM memory model.
// Read data returned by the model is (address ^ 32'hDEAD0000).
module tb_tcdm_stream_master;

    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, start_i, cfg_write_i;
    logic [31:0] cfg_base_addr_i, cfg_stride_i;
    logic [15:0] cfg_len_i;
    logic        busy_o, done_o;
    logic [31:0] in_data_i;
    logic        in_valid_i, in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o, out_ready_i;
    logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
    logic [31:0] tcdm_add_o, tcdm_data_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_r_data_i = 32'h0;
    logic        tcdm_r_valid_i = 1'b0;

    logic gnt_en, rand_gnt, hold_rsp;
    logic gnt_rnd = 1'b1;
    assign tcdm_gnt_i = gnt_en & (gnt_rnd | ~rand_gnt);

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    tcdm_stream_master #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_stride_i    (cfg_stride_i),
        .cfg_len_i       (cfg_len_i),
        .cfg_write_i     (cfg_write_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_data_o      (out_data_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .tcdm_req_o      (tcdm_req_o),
        .tcdm_gnt_i      (tcdm_gnt_i),
        .tcdm_add_o      (tcdm_add_o),
        .tcdm_wen_o      (tcdm_wen_o),
        .tcdm_be_o       (tcdm_be_o),
        .tcdm_data_o     (tcdm_data_o),
        .tcdm_r_data_i   (tcdm_r_data_i),
        .tcdm_r_valid_i  (tcdm_r_valid_i)
    );

    // Memory model: grant -> response one cycle later, or queued while hold_rsp.
    logic [31:0] wmem [logic [31:0]];
    logic [31:0] rsp_q [$];
    always @(posedge clk_i) begin
        tcdm_r_valid_i <= 1'b0;
        gnt_rnd <= 1'($urandom_range(0, 1));
        if (tcdm_req_o && tcdm_gnt_i) begin
            if (!tcdm_wen_o) wmem[tcdm_add_o] = tcdm_data_o;
            rsp_q.push_back(tcdm_wen_o ? (tcdm_add_o ^ 32'hDEAD0000) : 32'h0);
        end
        if (!hold_rsp && rsp_q.size() != 0) begin
            tcdm_r_valid_i <= 1'b1;
            tcdm_r_data_i  <= rsp_q.pop_front();
        end
    end

    // Monitor: grants, stream outputs, done pulses, responses, request stability.
    int cyc = 0, ngnt = 0, ndone = 0, nrv = 0, stab_viol = 0, done_rv = 0;
    logic [31:0] gaddr [$];
    int          gcyc [$];
    logic [31:0] outq [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_add = 32'h0, prev_data = 32'h0;
    logic        prev_wen = 1'b0;
    always @(posedge clk_i) begin
        cyc++;
        if (prev_stall && !(tcdm_req_o && tcdm_add_o == prev_add &&
                            tcdm_data_o == prev_data && tcdm_wen_o == prev_wen))
            stab_viol++;
        prev_stall = tcdm_req_o & ~tcdm_gnt_i & ~clear_i & rst_ni;
        prev_add   = tcdm_add_o;
        prev_data  = tcdm_data_o;
        prev_wen   = tcdm_wen_o;
        if (tcdm_req_o && tcdm_gnt_i) begin
            ngnt++;
            gaddr.push_back(tcdm_add_o);
            gcyc.push_back(cyc);
        end
        if (done_o) begin
            ndone++;
            done_rv = nrv;
        end
        if (tcdm_r_valid_i) nrv++;
        if (out_valid_o && out_ready_i) outq.push_back(out_data_o);
    end

    function automatic logic [31:0] gq(input int i);
        if (i < gaddr.size()) return gaddr[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] oq(input int i);
        if (i < outq.size()) return outq[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic int gc(input int i);
        if (i < gcyc.size()) return gcyc[i];
        return -1000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return 32'hxxxxxxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        d0 = ndone;
        for (int i = 0; i < bound && ndone == d0; i++) @(negedge clk_i);
        chk(tag, 32'(ndone - d0), 32'd1);
    endtask

    task automatic launch(input logic [31:0] base, input logic [31:0] stride,
                          input logic [15:0] len, input logic wr);
        cfg_base_addr_i = base;
        cfg_stride_i    = stride;
        cfg_len_i       = len;
        cfg_write_i     = wr;
        start_i         = 1'b1;
        @(negedge clk_i);
        start_i         = 1'b0;
    endtask

    logic [31:0] wdat [5] = '{32'h11111111, 32'h22222222, 32'h33333333,
                             32'h44444444, 32'h55555555};

    initial begin
        int g0, o0, d0, r0;
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; cfg_write_i = 1'b0;
        cfg_base_addr_i = 32'h0; cfg_stride_i = 32'h0; cfg_len_i = 16'h0;
        in_data_i = 32'h0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        gnt_en = 1'b1; rand_gnt = 1'b0; hold_rsp = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_req", 32'(tcdm_req_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_add", tcdm_add_o, 32'h0);
        chk("rst_out_data", out_data_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Read, base 0x100, stride 4, len 8, full throughput
        g0 = gaddr.size(); o0 = outq.size(); d0 = ndone;
        launch(32'h100, 32'h4, 16'd8, 1'b0);
        chk("t1_first_req", 32'(tcdm_req_o), 32'd1);
        chk("t1_first_add", tcdm_add_o, 32'h100);
        chk("t1_first_wen", 32'(tcdm_wen_o), 32'd1);
        chk("t1_first_be", 32'(tcdm_be_o), 32'hF);
        chk("t1_busy", 32'(busy_o), 32'd1);
        wait_done("t1_done", 60);
        for (int k = 0; k < 8; k++) begin
            chk("t1_add", gq(g0 + k), 32'h100 + 32'(4 * k));
            chk("t1_data", oq(o0 + k), 32'hDEAD0100 + 32'(4 * k));
        end
        chk("t1_back_to_back", 32'(gc(g0 + 7) - gc(g0)), 32'd7);
        repeat (3) @(negedge clk_i);
        chk("t1_ngnt", 32'(gaddr.size() - g0), 32'd8);
        chk("t1_req_idle", 32'(tcdm_req_o), 32'd0);
        chk("t1_busy_idle", 32'(busy_o), 32'd0);
        chk("t1_done_once", 32'(ndone - d0), 32'd1);

        // Read with negative stride wrapping through zero
        g0 = gaddr.size(); o0 = outq.size();
        launch(32'h8, 32'hFFFFFFFC, 16'd4, 1'b0);
        wait_done("t2_done", 40);
        chk("t2_add0", gq(g0 + 0), 32'h8);
        chk("t2_add1", gq(g0 + 1), 32'h4);
        chk("t2_add2", gq(g0 + 2), 32'h0);
        chk("t2_add3", gq(g0 + 3), 32'hFFFFFFFC);
        chk("t2_data0", oq(o0 + 0), 32'hDEAD0008);
        chk("t2_data3", oq(o0 + 3), 32'h2152FFFC);

        // Read len 16 with output back-pressure: credit limit of 4
        g0 = gaddr.size(); o0 = outq.size();
        out_ready_i = 1'b0;
        launch(32'h200, 32'h4, 16'd16, 1'b0);
        repeat (20) @(negedge clk_i);
        chk("t3_credit_gnts", 32'(gaddr.size() - g0), 32'd4);
        chk("t3_req_low", 32'(tcdm_req_o), 32'd0);
        chk("t3_out_valid", 32'(out_valid_o), 32'd1);
        chk("t3_out_head", out_data_o, 32'hDEAD0200);
        out_ready_i = 1'b1;
        wait_done("t3_done", 100);
        chk("t3_nout", 32'(outq.size() - o0), 32'd16);
        for (int k = 0; k < 16; k++)
            chk("t3_data", oq(o0 + k), 32'hDEAD0200 + 32'(4 * k));

        // Write, base 0x40, stride 8, len 5, random grant stalls
        r0 = nrv;
        rand_gnt = 1'b1;
        launch(32'h40, 32'h8, 16'd5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_data_i  = wdat[k];
            in_valid_i = 1'b1;
            for (int t = 0; t < 50; t++) begin
                if (in_ready_o) break;
                @(negedge clk_i);
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        wait_done("t4_done", 100);
        rand_gnt = 1'b0;
        for (int k = 0; k < 5; k++)
            chk("t4_mem", mem_rd(32'h40 + 32'(8 * k)), wdat[k]);
        chk("t4_done_after_rv", 32'(done_rv - r0), 32'd5);
        chk("t4_stable", 32'(stab_viol), 32'd0);

        // Zero-length transfer
        g0 = gaddr.size();
        launch(32'h500, 32'h4, 16'd0, 1'b0);
        chk("t5_busy", 32'(busy_o), 32'd1);
        chk("t5_done_early", 32'(done_o), 32'd0);
        chk("t5_req", 32'(tcdm_req_o), 32'd0);
        @(negedge clk_i);
        chk("t5_done", 32'(done_o), 32'd1);
        @(negedge clk_i);
        chk("t5_done_off", 32'(done_o), 32'd0);
        chk("t5_idle", 32'(busy_o), 32'd0);
        chk("t5_no_gnt", 32'(gaddr.size() - g0), 32'd0);

        // Clear with two reads outstanding, then a fresh len-2 read
        d0 = ndone; r0 = nrv; g0 = ngnt;
        hold_rsp = 1'b1;
        launch(32'h300, 32'h4, 16'd8, 1'b0);
        for (int t = 0; t < 20; t++) begin
            if (ngnt - g0 >= 2) break;
            @(negedge clk_i);
        end
        chk("t6_two_gnt", 32'(ngnt - g0), 32'd2);
        gnt_en  = 1'b0;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("t6_busy_drop", 32'(busy_o), 32'd0);
        chk("t6_out_valid", 32'(out_valid_o), 32'd0);
        chk("t6_req_drop", 32'(tcdm_req_o), 32'd0);
        gnt_en   = 1'b1;
        hold_rsp = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("t6_late_rv_seen", 32'(nrv - r0), 32'd2);
        chk("t6_late_ignored", 32'(out_valid_o), 32'd0);
        chk("t6_no_done", 32'(ndone - d0), 32'd0);
        chk("t6_still_idle", 32'(busy_o), 32'd0);
        o0 = outq.size();
        launch(32'h400, 32'h4, 16'd2, 1'b0);
        wait_done("t6_new_done", 40);
        chk("t6_new_nout", 32'(outq.size() - o0), 32'd2);
        chk("t6_new_data0", oq(o0 + 0), 32'hDEAD0400);
        chk("t6_new_data1", oq(o0 + 1), 32'hDEAD0404);

        chk("stab_total", 32'(stab_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
